window_accum: RTL and testbench

Downstream consumer of the window-segmentation stage. Takes the 76-bit complex sample stream, already cut into windows by `tlast`, and coherently sums the real and imaginary parts over each window. It emits one result beat per window carrying the two sums, the window length and a running window index. Its outputs feed the per-window detection and statistics logic.

---
 rtl/window_accum.sv | 115 +++++++++++
 tb/tb_window_accum.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_accum.sv
// Coherent per-window accumulator: sums complex samples over each tlast-delimited
// window and emits one {sum_re, sum_im} result beat with window length and index.
`timescale 1ns/1ps
module window_accum #(
    parameter int unsigned MAX_CNT  = 100,
    parameter int unsigned SAMPLE_W = 38,
    parameter int unsigned ACC_W    = 46
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*SAMPLE_W-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [2*ACC_W-1:0]    m_axis_tdata,
    output logic [31:0]           m_axis_tuser,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  o_force_close
);

    typedef enum logic [1:0] {EMPTY, ACCUM, STALL} state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic signed [ACC_W-1:0]   smp_re, smp_im, sum_re, sum_im;
    logic [15:0]               cnt_q, cnt_d, widx_q, widx_d;
    logic                      o_valid_q, o_valid_d;
    logic [2*ACC_W-1:0]        o_data_q, o_data_d;
    logic [31:0]               o_user_q, o_user_d;
    logic                      fc_q, fc_d;
    logic                      accept, at_limit, closing;

    // STALL is exactly "result register occupied", so it gates the input side.
    assign s_axis_tready = (state_q != STALL) | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign at_limit      = (cnt_q == 16'(MAX_CNT - 1));
    assign closing       = accept & (s_axis_tlast | at_limit);

    assign smp_re = {{(ACC_W-SAMPLE_W){s_axis_tdata[2*SAMPLE_W-1]}},
                     s_axis_tdata[2*SAMPLE_W-1:SAMPLE_W]};
    assign smp_im = {{(ACC_W-SAMPLE_W){s_axis_tdata[SAMPLE_W-1]}},
                     s_axis_tdata[SAMPLE_W-1:0]};
    assign sum_re = acc_re_q + smp_re;
    assign sum_im = acc_im_q + smp_im;

    always_comb begin
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        cnt_d     = cnt_q;
        widx_d    = widx_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_user_d  = o_user_q;
        fc_d      = 1'b0;

        if (o_valid_q && m_axis_tready)
            o_valid_d = 1'b0;

        if (closing) begin
            o_valid_d = 1'b1;
            o_data_d  = {sum_re, sum_im};
            o_user_d  = {widx_q, cnt_q + 16'd1};
            widx_d    = widx_q + 16'd1;
            acc_re_d  = '0;
            acc_im_d  = '0;
            cnt_d     = '0;
            // A closing beat without tlast can only be the length limit.
            fc_d      = ~s_axis_tlast;
        end else if (accept) begin
            acc_re_d  = sum_re;
            acc_im_d  = sum_im;
            cnt_d     = cnt_q + 16'd1;
        end

        if (o_valid_d)
            state_d = STALL;
        else if (cnt_d == '0)
            state_d = EMPTY;
        else
            state_d = ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            acc_re_q  <= '0;
            acc_im_q  <= '0;
            cnt_q     <= '0;
            widx_q    <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_user_q  <= '0;
            fc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_re_q  <= acc_re_d;
            acc_im_q  <= acc_im_d;
            cnt_q     <= cnt_d;
            widx_q    <= widx_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_user_q  <= o_user_d;
            fc_q      <= fc_d;
        end
    end

    assign m_axis_tvalid = o_valid_q;
    assign m_axis_tdata  = o_data_q;
    assign m_axis_tuser  = o_user_q;
    assign m_axis_tlast  = o_valid_q;
    assign o_force_close = fc_q;

endmodule

// File: tb/tb_window_accum.sv
// Directed bench for window_accum: hand-computed sums, lengths and indices per scenario.
`timescale 1ns/1ps
module tb_window_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [75:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [91:0] m_tdata;
    logic [31:0] m_tuser;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic        fc;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [15:0] idx = '0;

    window_accum #(.MAX_CNT(100), .SAMPLE_W(38), .ACC_W(46)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready), .o_force_close(fc)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic send(input logic [37:0] re, input logic [37:0] im, input logic last);
        s_tdata  = {re, im};
        s_tlast  = last;
        s_tvalid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idx = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
        total++; if (m_tdata !== 92'd0) begin bad++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
        total++; if (m_tuser !== 32'd0) begin bad++; $display("FAIL reset_tuser got=%h exp=0", m_tuser); end
        total++; if (fc !== 1'b0) begin bad++; $display("FAIL reset_force got=%b exp=0", fc); end
        total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_tready got=%b exp=1", s_tready); end
    endtask

    task automatic test_basic();
        logic [91:0] exp_d;
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b1;
        @(posedge clk); #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL ignored_tlast got=%b exp=0", m_tvalid); end
        for (int i = 1; i <= 5; i++) begin
            send(38'(i), 38'(-i), i == 5);
            if (i < 5) begin
                total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL basic_early_valid beat=%0d got=%b exp=0", i, m_tvalid); end
            end
        end
        exp_d = {46'(15), 46'(-15)};
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", m_tvalid); end
        total++; if (m_tlast !== 1'b1) begin bad++; $display("FAIL basic_tlast got=%b exp=1", m_tlast); end
        total++; if (m_tdata !== exp_d) begin bad++; $display("FAIL basic_data got=%h exp=%h", m_tdata, exp_d); end
        total++; if (m_tuser !== {idx, 16'd5}) begin bad++; $display("FAIL basic_user got=%h exp=%h", m_tuser, {idx, 16'd5}); end
        total++; if (fc !== 1'b0) begin bad++; $display("FAIL basic_force got=%b exp=0", fc); end
        idx++;
        idle();
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL basic_taken got=%b exp=0", m_tvalid); end
    endtask

    task automatic test_force_close();
        longint p, n;
        logic [91:0] exp_d;
        p = (longint'(1) <<< 37) - 1;
        n = -(longint'(1) <<< 37);
        m_tready = 1'b1;
        exp_d = {46'(longint'(100) * p), 46'(longint'(100) * n)};
        for (int i = 1; i <= 250; i++) begin
            send(38'h1F_FFFF_FFFF, 38'h20_0000_0000, 1'b0);
            if (i == 100 || i == 200) begin
                total++; if (fc !== 1'b1) begin bad++; $display("FAIL force_pulse beat=%0d got=%b exp=1", i, fc); end
                total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL force_valid beat=%0d got=%b exp=1", i, m_tvalid); end
                total++; if (m_tdata !== exp_d) begin bad++; $display("FAIL force_data beat=%0d got=%h exp=%h", i, m_tdata, exp_d); end
                total++; if (m_tuser !== {idx, 16'd100}) begin bad++; $display("FAIL force_user beat=%0d got=%h exp=%h", i, m_tuser, {idx, 16'd100}); end
                idx++;
            end else begin
                total++; if (fc !== 1'b0) begin bad++; $display("FAIL force_quiet beat=%0d got=%b exp=0", i, fc); end
            end
        end
        send('0, '0, 1'b1);
        exp_d = {46'(longint'(50) * p), 46'(longint'(50) * n)};
        total++; if (m_tdata !== exp_d) begin bad++; $display("FAIL remainder_data got=%h exp=%h", m_tdata, exp_d); end
        total++; if (m_tuser !== {idx, 16'd51}) begin bad++; $display("FAIL remainder_user got=%h exp=%h", m_tuser, {idx, 16'd51}); end
        total++; if (fc !== 1'b0) begin bad++; $display("FAIL remainder_force got=%b exp=0", fc); end
        idx++;
        idle();
    endtask

    task automatic test_limit_with_last();
        logic [91:0] exp_d;
        m_tready = 1'b1;
        for (int i = 1; i <= 100; i++) send(38'd1, 38'd0, i == 100);
        exp_d = {46'(100), 46'(0)};
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL limit_last_valid got=%b exp=1", m_tvalid); end
        total++; if (m_tdata !== exp_d) begin bad++; $display("FAIL limit_last_data got=%h exp=%h", m_tdata, exp_d); end
        total++; if (m_tuser !== {idx, 16'd100}) begin bad++; $display("FAIL limit_last_user got=%h exp=%h", m_tuser, {idx, 16'd100}); end
        total++; if (fc !== 1'b0) begin bad++; $display("FAIL limit_last_force got=%b exp=0", fc); end
        idx++;
        idle();
    endtask

    task automatic test_back_to_back();
        logic [91:0] exp_d;
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(38'(i + 1), 38'(-2 * i), 1'b1);
            exp_d = {46'(i + 1), 46'(-2 * i)};
            total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL b2b_valid n=%0d got=%b exp=1", i, m_tvalid); end
            total++; if (m_tdata !== exp_d) begin bad++; $display("FAIL b2b_data n=%0d got=%h exp=%h", i, m_tdata, exp_d); end
            total++; if (m_tuser !== {idx, 16'd1}) begin bad++; $display("FAIL b2b_user n=%0d got=%h exp=%h", i, m_tuser, {idx, 16'd1}); end
            total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL b2b_tready n=%0d got=%b exp=1", i, s_tready); end
            idx++;
        end
        idle();
    endtask

    task automatic test_stall();
        logic [91:0] exp_d;
        m_tready = 1'b0;
        send(38'd7, 38'd3, 1'b1);
        exp_d = {46'(7), 46'(3)};
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL stall_load got=%b exp=1", m_tvalid); end
        s_tdata = {38'd9, 38'd4};
        s_tlast = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL stall_tready c=%0d got=%b exp=0", c, s_tready); end
            total++; if (m_tvalid !== 1'b1 || m_tdata !== exp_d || m_tuser !== {idx, 16'd1}) begin
                bad++; $display("FAIL stall_hold c=%0d got=%b/%h/%h exp=1/%h/%h", c, m_tvalid, m_tdata, m_tuser, exp_d, {idx, 16'd1});
            end
        end
        idx++;
        m_tready = 1'b1;
        #1;
        total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL release_tready got=%b exp=1", s_tready); end
        @(posedge clk); #1;
        exp_d = {46'(9), 46'(4)};
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL handoff_valid got=%b exp=1", m_tvalid); end
        total++; if (m_tdata !== exp_d) begin bad++; $display("FAIL handoff_data got=%h exp=%h", m_tdata, exp_d); end
        total++; if (m_tuser !== {idx, 16'd1}) begin bad++; $display("FAIL handoff_user got=%h exp=%h", m_tuser, {idx, 16'd1}); end
        idx++;
        idle();
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL handoff_drain got=%b exp=0", m_tvalid); end
    endtask

    task automatic test_reset_mid();
        logic [91:0] exp_d;
        m_tready = 1'b0;
        send(38'd5, 38'd5, 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL pending_before_reset got=%b exp=1", m_tvalid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL async_drop got=%b exp=0", m_tvalid); end
        total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL async_tready got=%b exp=1", s_tready); end
        @(posedge clk); #1 rst_n = 1'b1;
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) send(38'd100, 38'd100, 1'b0);
        s_tvalid = 1'b0;
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        idx = '0;
        send(38'd10, -38'sd1, 1'b0);
        send(38'd20, -38'sd2, 1'b1);
        exp_d = {46'(30), 46'(-3)};
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL post_reset_valid got=%b exp=1", m_tvalid); end
        total++; if (m_tdata !== exp_d) begin bad++; $display("FAIL post_reset_data got=%h exp=%h", m_tdata, exp_d); end
        total++; if (m_tuser !== {16'd0, 16'd2}) begin bad++; $display("FAIL post_reset_user got=%h exp=%h", m_tuser, {16'd0, 16'd2}); end
        idle();
    endtask

    task automatic test_wrap();
        apply_reset();
        m_tready = 1'b1;
        for (int i = 1; i <= 65537; i++) begin
            send('0, '0, 1'b1);
            if (i == 1 || i == 65536 || i == 65537) begin
                total++; if (m_tvalid !== 1'b1 || m_tuser !== {idx, 16'd1}) begin
                    bad++; $display("FAIL wrap_idx n=%0d got=%b/%h exp=1/%h", i, m_tvalid, m_tuser, {idx, 16'd1});
                end
            end
            idx++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_force_close();
        test_limit_with_last();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
